// File: rtl/char_buf_pkg.sv
// Shared definitions for the character buffer controller: state encoding,
// requester identities and default widths / blank code.
package char_buf_pkg;

    localparam int             ADDR_W_DEF     = 8;
    localparam int             CODE_W_DEF     = 7;
    localparam logic [6:0]     BLANK_CODE_DEF = 7'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/char_buf_ram.sv
// Character RAM: one synchronous write port and one registered read-first
// read port, written in the plain style that maps onto block RAM.
module char_buf_ram
    import char_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/char_buf_ctrl.sv
// Character buffer controller: round-robin arbitration of two writers into the
// character RAM, with an optional full-screen clear engine (CHAR_BUF_CLEAR_EN).
module char_buf_ctrl
    import char_buf_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                CODE_W     = CODE_W_DEF,
    parameter logic [CODE_W-1:0] BLANK_CODE = CODE_W'(BLANK_CODE_DEF)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [CODE_W-1:0] data_a,
    input  logic [CODE_W-1:0] data_b,
    output logic              ack_a,
    output logic              ack_b,
    input  logic              clear_req,
    output logic              busy
);

    state_t            state;
    state_t            next_state;
    grant_t            last_grant;
    logic              grant_a;
    logic              grant_b;
    logic              start_clear;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CODE_W-1:0] wdata;

`ifdef CHAR_BUF_CLEAR_EN
    logic [ADDR_W-1:0] cnt;
    logic              clear_pend;

    assign start_clear = clear_req || clear_pend;
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign start_clear      = 1'b0;
    assign busy             = 1'b0;
`endif

    always_comb begin
        next_state = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        we         = 1'b0;
        waddr      = addr_a;
        wdata      = data_a;
        case (state)
            IDLE: begin
                if (start_clear) begin
                    next_state = CLEAR;
                end else if (req_a && (!req_b || last_grant == GRANT_B)) begin
                    grant_a    = 1'b1;
                    we         = 1'b1;
                    next_state = ACK;
                end else if (req_b) begin
                    grant_b    = 1'b1;
                    we         = 1'b1;
                    waddr      = addr_b;
                    wdata      = data_b;
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
`ifdef CHAR_BUF_CLEAR_EN
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
                wdata = BLANK_CODE;
                if (cnt == '1) begin
                    next_state = IDLE;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A request granted in the same cycle as reset is dropped along with its ack.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            last_grant <= GRANT_B;
        end else begin
            state <= next_state;
            ack_a <= grant_a;
            ack_b <= grant_b;
            if (grant_a) begin
                last_grant <= GRANT_A;
            end else if (grant_b) begin
                last_grant <= GRANT_B;
            end
        end
    end

`ifdef CHAR_BUF_CLEAR_EN
    // clear_pend arms a clear on reset release so every reset restarts from cell 0.
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt        <= '0;
            busy       <= 1'b0;
            clear_pend <= 1'b1;
        end else begin
            busy <= (next_state == CLEAR);
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (next_state == CLEAR) begin
                clear_pend <= 1'b0;
            end
        end
    end
`endif

    char_buf_ram #(
        .ADDR_W(ADDR_W),
        .CODE_W(CODE_W)
    ) u_ram (
        .clk  (pclk),
        .rst  (rst),
        .we   (we && !rst),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(char_xy),
        .rdata(char_code)
    );

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Directed bench for char_buf_ctrl: table of per-cycle vectors plus hand
// sequences for reset and clear corner cases (CHAR_BUF_CLEAR_EN aware).
module tb_char_buf_ctrl;

    logic       pclk;
    logic       rst;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic       req_a;
    logic       req_b;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] data_a;
    logic [6:0] data_b;
    logic       ack_a;
    logic       ack_b;
    logic       clear_req;
    logic       busy;

    int checks = 0;
    int passes = 0;

    char_buf_ctrl dut (
        .pclk     (pclk),
        .rst      (rst),
        .char_xy  (char_xy),
        .char_code(char_code),
        .req_a    (req_a),
        .req_b    (req_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .clear_req(clear_req),
        .busy     (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Inputs for one cycle, and the outputs expected just after that cycle's edge.
    typedef struct packed {
        logic       req_a;
        logic [7:0] addr_a;
        logic [6:0] data_a;
        logic       req_b;
        logic [7:0] addr_b;
        logic [6:0] data_b;
        logic [7:0] xy;
        logic       exp_ack_a;
        logic       exp_ack_b;
        logic [6:0] exp_code;
        logic       chk_code;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic ra, input logic [7:0] aa, input logic [6:0] da,
                                input logic rb, input logic [7:0] ab, input logic [6:0] db,
                                input logic [7:0] xy, input logic ea, input logic eb,
                                input logic [6:0] ec, input logic cc);
        vec_t v;
        v.req_a = ra; v.addr_a = aa; v.data_a = da;
        v.req_b = rb; v.addr_b = ab; v.data_b = db;
        v.xy = xy; v.exp_ack_a = ea; v.exp_ack_b = eb;
        v.exp_code = ec; v.chk_code = cc;
        return v;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_a   = v.req_a;
        addr_a  = v.addr_a;
        data_a  = v.data_a;
        req_b   = v.req_b;
        addr_b  = v.addr_b;
        data_b  = v.data_b;
        char_xy = v.xy;
        tick();
    endtask

    task automatic measureBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic readCell(input logic [7:0] xy, input logic [6:0] expected, input string name);
        char_xy = xy;
        tick();
        checkOutput(name, char_code, expected);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int stray;

        vecs[0]  = mk(1, 8'h10, 7'h31, 1, 8'h20, 7'h32, 8'h00, 1, 0, 7'h00, 0);
        vecs[1]  = mk(1, 8'h10, 7'h31, 1, 8'h20, 7'h32, 8'h00, 0, 0, 7'h00, 0);
        vecs[2]  = mk(1, 8'h10, 7'h31, 1, 8'h20, 7'h32, 8'h00, 0, 1, 7'h00, 0);
        vecs[3]  = mk(1, 8'h10, 7'h31, 1, 8'h20, 7'h32, 8'h00, 0, 0, 7'h00, 0);
        vecs[4]  = mk(1, 8'h11, 7'h33, 1, 8'h20, 7'h32, 8'h10, 1, 0, 7'h31, 1);
        vecs[5]  = mk(1, 8'h11, 7'h33, 1, 8'h20, 7'h32, 8'h20, 0, 0, 7'h32, 1);
        vecs[6]  = mk(1, 8'h11, 7'h33, 1, 8'h21, 7'h34, 8'h11, 0, 1, 7'h33, 1);
        vecs[7]  = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h21, 0, 0, 7'h34, 1);
        vecs[8]  = mk(1, 8'h12, 7'h41, 0, 8'h00, 7'h00, 8'h12, 1, 0, 7'h00, 0);
        vecs[9]  = mk(1, 8'h12, 7'h41, 0, 8'h00, 7'h00, 8'h12, 0, 0, 7'h41, 1);
        vecs[10] = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h12, 0, 0, 7'h41, 1);
        vecs[11] = mk(0, 8'h00, 7'h00, 1, 8'h30, 7'h55, 8'h30, 0, 1, 7'h00, 0);
        vecs[12] = mk(0, 8'h00, 7'h00, 1, 8'h30, 7'h55, 8'h30, 0, 0, 7'h55, 1);
        vecs[13] = mk(0, 8'h00, 7'h00, 1, 8'h30, 7'h56, 8'h30, 0, 1, 7'h55, 1);
        vecs[14] = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h30, 0, 0, 7'h56, 1);
        vecs[15] = mk(1, 8'h05, 7'h20, 0, 8'h00, 7'h00, 8'h05, 1, 0, 7'h00, 0);
        vecs[16] = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h05, 0, 0, 7'h20, 1);
        vecs[17] = mk(1, 8'h05, 7'h42, 0, 8'h00, 7'h00, 8'h05, 1, 0, 7'h20, 1);
        vecs[18] = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h05, 0, 0, 7'h42, 1);
        vecs[19] = mk(1, 8'h13, 7'h44, 1, 8'h31, 7'h45, 8'h13, 0, 1, 7'h00, 0);
        vecs[20] = mk(0, 8'h00, 7'h00, 0, 8'h00, 7'h00, 8'h31, 0, 0, 7'h45, 1);

        rst = 1'b1; char_xy = 8'h00; req_a = 1'b0; req_b = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; data_a = 7'h00; data_b = 7'h00; clear_req = 1'b0;
        repeat (3) tick();
        req_a = 1'b1; clear_req = 1'b1;
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ack_a", ack_a, 0);
        checkOutput("reset_ack_b", ack_b, 0);
        checkOutput("reset_code", char_code, 0);
        req_a = 1'b0; clear_req = 1'b0;
        rst = 1'b0;

`ifdef CHAR_BUF_CLEAR_EN
        tick();
        checkOutput("release_enters_clear", busy, 1);
        measureBusy(n);
        checkOutput("release_clear_cycles", n, 256);
        readCell(8'h00, 7'h20, "blank_00");
        readCell(8'h7F, 7'h20, "blank_7F");
        readCell(8'hFF, 7'h20, "blank_FF");
`else
        tick();
        checkOutput("release_idle_busy", busy, 0);
`endif

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ack_a", i), ack_a, vecs[i].exp_ack_a);
            checkOutput($sformatf("vec%0d_ack_b", i), ack_b, vecs[i].exp_ack_b);
            if (vecs[i].chk_code) begin
                checkOutput($sformatf("vec%0d_code", i), char_code, vecs[i].exp_code);
            end
        end

`ifdef CHAR_BUF_CLEAR_EN
        // Clear wins over a simultaneous write; req_b stalls until the clear ends.
        clear_req = 1'b1; req_b = 1'b1; addr_b = 8'h50; data_b = 7'h77;
        tick();
        checkOutput("clear_priority_busy", busy, 1);
        checkOutput("clear_priority_ack_b", ack_b, 0);
        n = 0; stray = 0;
        while (busy === 1'b1 && n < 1000) begin
            clear_req = (n == 40);
            tick();
            n++;
            if (ack_b !== 1'b0) stray++;
        end
        clear_req = 1'b0;
        checkOutput("stalled_clear_cycles", n, 256);
        checkOutput("stalled_no_ack_b", stray, 0);
        tick();
        checkOutput("ack_b_after_clear", ack_b, 1);
        req_b = 1'b0;
        readCell(8'h50, 7'h77, "b_data_kept");
        readCell(8'h7F, 7'h20, "blank_after_clear");

        // Reset at cnt=100 must restart a full clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checkOutput("clear2_busy", busy, 1);
        repeat (100) tick();
        rst = 1'b1;
        tick();
        checkOutput("midclear_rst_busy", busy, 0);
        checkOutput("midclear_rst_code", char_code, 0);
        rst = 1'b0;
        tick();
        checkOutput("restart_busy", busy, 1);
        measureBusy(n);
        checkOutput("restart_clear_cycles", n, 256);

        req_a = 1'b1; addr_a = 8'h61; data_a = 7'h12; rst = 1'b1;
        tick();
        checkOutput("rst_grant_ack_a", ack_a, 0);
        req_a = 1'b0; rst = 1'b0;
        tick();
        measureBusy(n);
        checkOutput("rst_grant_clear_cycles", n, 256);
`else
        // clear_req has no effect; writes proceed and RAM survives reset.
        clear_req = 1'b1; req_a = 1'b1; addr_a = 8'h60; data_a = 7'h66;
        tick();
        checkOutput("noclr_busy", busy, 0);
        checkOutput("noclr_ack_a", ack_a, 1);
        clear_req = 1'b0; req_a = 1'b0;
        tick();
        req_a = 1'b1; addr_a = 8'h61; data_a = 7'h33;
        tick();
        checkOutput("noclr_ack_a_61", ack_a, 1);
        req_a = 1'b0;
        tick();
        req_a = 1'b1; addr_a = 8'h61; data_a = 7'h12; rst = 1'b1;
        tick();
        checkOutput("rst_grant_ack_a", ack_a, 0);
        checkOutput("rst_busy", busy, 0);
        req_a = 1'b0; rst = 1'b0;
        tick();
        checkOutput("post_rst_busy", busy, 0);
        readCell(8'h60, 7'h66, "ram_kept_60");
        readCell(8'h61, 7'h33, "aborted_write_61");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/char_buf_ctrl.md
CHAR_BUF_CTRL -- requirements
Module: char_buf_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 8, giving the character-cell address width (16x16 cells, {row[3:0], col[3:0]}).
REQ-002 The block SHALL have the parameter CODE_W, default 7, giving the character-code width.
REQ-003 The block SHALL have the parameter BLANK_CODE, default 7'h20, giving the code written by the clear engine.
REQ-004 The block SHALL have the port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port char_xy, input, ADDR_W bits: the cell address requested by the character-drawing stage.
REQ-007 The block SHALL have the port char_code, output, CODE_W bits: the registered code of the cell at char_xy.
REQ-008 The block SHALL have the ports req_a and req_b, input, 1 bit each: write requests from requester A and requester B.
REQ-009 The block SHALL have the ports addr_a and addr_b, input, ADDR_W bits each: the write cell address of each requester.
REQ-010 The block SHALL have the ports data_a and data_b, input, CODE_W bits each: the write code of each requester.
REQ-011 The block SHALL have the ports ack_a and ack_b, output, 1 bit each: one-cycle write-done pulses.
REQ-012 The block SHALL have the port clear_req, input, 1 bit: a request to fill every cell with BLANK_CODE.
REQ-013 The block SHALL have the port busy, output, 1 bit: high while a clear is in progress.

Function
REQ-014 The block SHALL hold a 2^ADDR_W x CODE_W character RAM with one read port and one write port.
REQ-015 char_code SHALL be the RAM content at char_xy, one pclk later, in every state.
REQ-016 A same-cycle read and write to the same cell SHALL return the old data (read-first).
REQ-017 The block SHALL implement the FSM states IDLE, ACK and CLEAR.
REQ-018 In IDLE with clear_req=1, the block SHALL go to CLEAR with cnt=0; clear_req SHALL take priority over write requests.
REQ-019 In IDLE with no clear_req and at least one req, the arbiter SHALL grant exactly one requester.
REQ-020 At the edge ending the grant cycle, the block SHALL write the granted requester's data to its address.
REQ-021 After a grant, the block SHALL go to ACK and drive the granted ack high for exactly that one cycle.
REQ-022 No grant SHALL be issued in ACK; the next state SHALL always be IDLE.
REQ-023 Arbitration SHALL be round-robin: when req_a and req_b are both high, the requester not granted last SHALL win, and last_grant SHALL be updated on every grant.
REQ-024 A requester SHALL drop req in the cycle after its ack; a req still high in IDLE after ACK SHALL be treated as a new request.
REQ-025 The maximum write throughput SHALL be one write per 2 cycles.
REQ-026 In CLEAR, each cycle the block SHALL write BLANK_CODE to cell cnt and increment cnt; after the write of cell 2^ADDR_W-1, the next state SHALL be IDLE.
REQ-027 A clear SHALL therefore take exactly 2^ADDR_W cycles.
REQ-028 busy SHALL be registered, high exactly in the CLEAR cycles.
REQ-029 In CLEAR, requests SHALL be stalled (no ack) and held by the requester; clear_req SHALL be ignored.

Reset
REQ-030 While rst=1, the state SHALL be IDLE and cnt, ack_a, ack_b, busy and char_code SHALL be 0; last_grant SHALL be B so that A wins the first tie.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 rst asserted mid-CLEAR or in ACK SHALL abort the operation at the next edge, and no ack SHALL be issued.

Configuration
REQ-033 With CHAR_BUF_CLEAR_EN defined, the CLEAR state, cnt, the clear_req path and the clear-on-reset-release behaviour SHALL be present.
REQ-034 With CHAR_BUF_CLEAR_EN defined, the first cycle after rst falls SHALL enter CLEAR.
REQ-035 Without CHAR_BUF_CLEAR_EN, the CLEAR state and cnt SHALL be absent, clear_req SHALL be ignored, busy SHALL be constant 0, and reset release SHALL go to IDLE.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE, ACK, CLEAR), the default widths and BLANK_CODE.
REQ-037 The RAM SHALL be a sub-module char_buf_ram (synchronous write, registered read-first read) so that it infers BRAM.

Verification
REQ-038 The bench SHALL cover: with the macro defined, after reset release, busy high for 256 cycles -> then char_code=7'h20 for char_xy=8'h00, 8'h7F and 8'hFF.
REQ-039 The bench SHALL cover: req_a with addr_a=8'h12, data_a=7'h41 -> ack_a pulses 2 cycles after req_a rises, and char_xy=8'h12 then reads 7'h41 one cycle later.
REQ-040 The bench SHALL cover: req_a and req_b held high continuously -> grants A,B,A,B, with an ack every 2 cycles, starting with A after reset.
REQ-041 The bench SHALL cover: req_b raised during a clear -> no ack_b while busy=1, and ack_b 2 cycles after busy falls, with its data not overwritten.
REQ-042 The bench SHALL cover: rst pulsed at cnt=100 of a clear -> the clear restarts from 0 with the macro, and busy=0 and IDLE without the macro.
REQ-043 The bench SHALL cover: a same-cycle write and read of cell 8'h05 (old 7'h20, new 7'h42) -> char_code=7'h20 next cycle, then 7'h42.
